// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode types, RV32I major-opcode constants and decode helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_IMM     = 4'd7,
    OP_REG     = 4'd8,
    OP_FENCE   = 4'd9,
    OP_SYSTEM  = 4'd10,
    OP_ILLEGAL = 4'd11
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // opcode[6:2] values
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  function automatic op_e decode_op(input logic [6:0] opcode);
    op_e op;
    op = OP_ILLEGAL;
    if (opcode[1:0] == 2'b11) begin
      case (opcode[6:2])
        OPC_LUI:      op = OP_LUI;
        OPC_AUIPC:    op = OP_AUIPC;
        OPC_JAL:      op = OP_JAL;
        OPC_JALR:     op = OP_JALR;
        OPC_BRANCH:   op = OP_BRANCH;
        OPC_LOAD:     op = OP_LOAD;
        OPC_STORE:    op = OP_STORE;
        OPC_OP_IMM:   op = OP_IMM;
        OPC_OP:       op = OP_REG;
        OPC_MISC_MEM: op = OP_FENCE;
        OPC_SYSTEM:   op = OP_SYSTEM;
        default:      op = OP_ILLEGAL;
      endcase
    end
    return op;
  endfunction

  function automatic imm_fmt_e imm_fmt(input op_e op);
    imm_fmt_e fmt;
    case (op)
      OP_LUI, OP_AUIPC:                     fmt = IMM_U;
      OP_JAL:                               fmt = IMM_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:  fmt = IMM_I;
      OP_BRANCH:                            fmt = IMM_B;
      OP_STORE:                             fmt = IMM_S;
      default:                              fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: assembles the I/S/B/U/J immediate and sign-extends it to XLEN.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  // scatter-gather of immediate bits per instruction format
  always_comb begin
    imm32 = '0;
    case (fmt_i)
      IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      IMM_U: imm32 = {instr_i[31:12], 12'h000};
      IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with ID/EX register and load-use stall.
// Optional macro DECODE_BYPASS_EN: forward same-cycle write-back data
// instead of stalling on a write-back collision.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            res,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  input  logic            flush,
  output logic [4:0]      A1,
  output logic [4:0]      A2,
  input  logic [XLEN-1:0] RD1,
  input  logic [XLEN-1:0] RD2,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [3:0]      ex_op
);

  op_e             dec_op;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rd;
  logic            use_rs1, use_rs2;
  logic            ex_hit, luse_hit, wb_hit1, wb_hit2, byp1, byp2, hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_q, ex_rd_d, luse_rd_q, luse_rd_d;
  logic [2:0]      ex_funct3_q, ex_funct3_d;
  logic            ex_funct7b5_q, ex_funct7b5_d;
  op_e             ex_op_q, ex_op_d;

  assign A1     = if_instr[19:15];
  assign A2     = if_instr[24:20];
  assign dec_op = decode_op(if_instr[6:0]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (if_instr[31:7]),
    .fmt_i   (imm_fmt(dec_op)),
    .imm_o   (dec_imm)
  );

  // source usage, with x0 never counting as a dependency
  always_comb begin
    use_rs1 = !(dec_op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_ILLEGAL}) && (A1 != '0);
    use_rs2 = (dec_op inside {OP_BRANCH, OP_STORE, OP_REG}) && (A2 != '0);
    dec_rd  = (dec_op inside {OP_BRANCH, OP_STORE, OP_FENCE, OP_ILLEGAL}) ? '0
                                                                          : if_instr[11:7];
  end

  // load-use: load still in ID/EX, or load that left on the previous edge
  always_comb begin
    ex_hit   = ex_valid_q && (ex_op_q == OP_LOAD) &&
               ((use_rs1 && A1 == ex_rd_q) || (use_rs2 && A2 == ex_rd_q));
    luse_hit = (use_rs1 && A1 == luse_rd_q) || (use_rs2 && A2 == luse_rd_q);
    wb_hit1  = (wb_rd != '0) && use_rs1 && (wb_rd == A1);
    wb_hit2  = (wb_rd != '0) && use_rs2 && (wb_rd == A2);
  end

`ifdef DECODE_BYPASS_EN
  assign byp1   = wb_hit1;
  assign byp2   = wb_hit2;
  assign hazard = ex_hit || luse_hit;
`else
  assign byp1   = 1'b0;
  assign byp2   = 1'b0;
  assign hazard = ex_hit || luse_hit || wb_hit1 || wb_hit2;
`endif

  assign rs1_val  = byp1 ? wb_data : RD1;
  assign rs2_val  = byp2 ? wb_data : RD2;
  assign if_ready = res && !flush && (!ex_valid_q || ex_ready) && !hazard;
  assign accept   = if_valid && if_ready;

  // ID/EX next state: flush beats accept, accept beats drain, else hold
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_imm_d      = ex_imm_q;
    ex_rd_d       = ex_rd_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    ex_op_d       = ex_op_q;
    luse_rd_d     = '0;
    if (ex_valid_q && ex_ready && ex_op_q == OP_LOAD) luse_rd_d = ex_rd_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      luse_rd_d  = '0;
    end else if (accept) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = XLEN'(if_pc);
      ex_rs1_d      = rs1_val;
      ex_rs2_d      = rs2_val;
      ex_imm_d      = dec_imm;
      ex_rd_d       = dec_rd;
      ex_funct3_d   = if_instr[14:12];
      ex_funct7b5_d = if_instr[30];
      ex_op_d       = dec_op;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // ID/EX and load-use tracking registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= RESET_PC;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_op_q       <= OP_LUI;
      luse_rd_q     <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_imm_q      <= ex_imm_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
      ex_op_q       <= ex_op_d;
      luse_rd_q     <= luse_rd_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_val  = ex_rs1_q;
  assign ex_rs2_val  = ex_rs2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rd       = ex_rd_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_funct7b5 = ex_funct7b5_q;
  assign ex_op       = ex_op_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (honours DECODE_BYPASS_EN).
module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  localparam logic [3:0] K_LUI = 4'd0, K_AUIPC = 4'd1, K_JAL = 4'd2, K_JALR = 4'd3,
                         K_BRANCH = 4'd4, K_LOAD = 4'd5, K_STORE = 4'd6, K_OPIMM = 4'd7,
                         K_OPREG = 4'd8, K_FENCE = 4'd9, K_SYSTEM = 4'd10, K_ILL = 4'd11;

  logic        clk, res, if_valid, if_ready, flush, ex_valid, ex_ready, ex_funct7b5;
  logic [31:0] if_instr, if_pc, RD1, RD2, wb_data, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  A1, A2, wb_rd, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_op;

  decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .res(res), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_op(ex_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register-file model feeding RD1/RD2
  logic [31:0] regs [32];
  assign RD1 = regs[A1];
  assign RD2 = regs[A2];

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [3:0]  op;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk = 0, n_fail = 0;
  logic        m_valid = 1'b0, accepted = 1'b0, rnd_rdy = 1'b0;
  logic [3:0]  m_op = '0, cur_op = '0;
  logic [4:0]  m_rd = '0, m_luse = '0, cur_rd = '0;
  logic [31:0] cur_imm = '0;
  int unsigned cyc;

  // instruction table: word, expected class, immediate, destination
  logic [31:0] t_ins [16] = '{32'h02A00293, 32'h0000A503, 32'h005505B3, 32'hFE21AE23,
                              32'hFE208CE3, 32'h123453B7, 32'h001000EF, 32'hFFFFF417,
                              32'h402081B3, 32'h0FF0000F, 32'h00000000, 32'h02A00290,
                              32'hFFF280E7, 32'h305094F3, 32'h8005A603, 32'h00C086B3};
  logic [3:0]  t_op  [16] = '{K_OPIMM, K_LOAD, K_OPREG, K_STORE, K_BRANCH, K_LUI, K_JAL,
                              K_AUIPC, K_OPREG, K_FENCE, K_ILL, K_ILL, K_JALR, K_SYSTEM,
                              K_LOAD, K_OPREG};
  logic [31:0] t_imm [16] = '{32'd42, 32'd0, 32'd0, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                              32'h00000800, 32'hFFFFF000, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'hFFFFFFFF, 32'h00000305, 32'hFFFFF800, 32'd0};
  logic [4:0]  t_rd  [16] = '{5'd5, 5'd10, 5'd11, 5'd0, 5'd0, 5'd7, 5'd1, 5'd8, 5'd3, 5'd0,
                              5'd0, 5'd0, 5'd1, 5'd9, 5'd12, 5'd13};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic reads1(input logic [3:0] op);
    return !(op == K_LUI || op == K_AUIPC || op == K_JAL || op == K_ILL);
  endfunction

  function automatic logic reads2(input logic [3:0] op);
    return (op == K_BRANCH || op == K_STORE || op == K_OPREG);
  endfunction

  // called at negedge: predict handshake, compare ID/EX, advance model
  task automatic sample();
    logic [4:0] r1, r2, nl;
    logic m1, m2, ldhz, wb1, wb2, hz, rdy, acc, leave;
    exp_t e;
    r1 = if_instr[19:15];
    r2 = if_instr[24:20];
    check("A1", A1, r1);
    check("A2", A2, r2);
    m1 = reads1(cur_op) && r1 != 0;
    m2 = reads2(cur_op) && r2 != 0;
    ldhz = (m_valid && m_op == K_LOAD && ((m1 && r1 == m_rd) || (m2 && r2 == m_rd))) ||
           ((m1 && r1 == m_luse) || (m2 && r2 == m_luse));
    wb1 = wb_rd != 0 && m1 && wb_rd == r1;
    wb2 = wb_rd != 0 && m2 && wb_rd == r2;
`ifdef DECODE_BYPASS_EN
    hz = ldhz;
`else
    hz = ldhz || wb1 || wb2;
`endif
    rdy = res && !flush && (!m_valid || ex_ready) && !hz;
    check("if_ready", if_ready, rdy);
    check("ex_valid", ex_valid, m_valid);
    if (m_valid && sb.size() != 0) begin
      e = sb[0];
      check("ex_pc", ex_pc, e.pc);
      check("ex_rs1_val", ex_rs1_val, e.rs1);
      check("ex_rs2_val", ex_rs2_val, e.rs2);
      check("ex_imm", ex_imm, e.imm);
      check("ex_rd", ex_rd, e.rd);
      check("ex_funct3", ex_funct3, e.f3);
      check("ex_funct7b5", ex_funct7b5, e.f7b5);
      check("ex_op", ex_op, e.op);
    end
    acc = 1'b0;
    if (!res) begin
      check("rst_pc", ex_pc, RST_PC);
      m_valid = 1'b0;
      m_luse  = '0;
      sb.delete();
    end else begin
      acc   = if_valid && rdy;
      leave = m_valid && ex_ready;
      nl    = (!flush && leave && m_op == K_LOAD) ? m_rd : 5'd0;
      if ((leave || flush) && m_valid && sb.size() != 0) void'(sb.pop_front());
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        e.pc   = if_pc;
`ifdef DECODE_BYPASS_EN
        e.rs1  = wb1 ? wb_data : regs[r1];
        e.rs2  = wb2 ? wb_data : regs[r2];
`else
        e.rs1  = regs[r1];
        e.rs2  = regs[r2];
`endif
        e.imm  = cur_imm;
        e.rd   = cur_rd;
        e.f3   = if_instr[14:12];
        e.f7b5 = if_instr[30];
        e.op   = cur_op;
        sb.push_back(e);
        m_valid = 1'b1;
        m_op    = cur_op;
        m_rd    = cur_rd;
      end else if (ex_ready) m_valid = 1'b0;
      m_luse = nl;
    end
    accepted = acc;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (wb_rd != 0) regs[wb_rd] = wb_data;
    wb_rd = '0;
    if (rnd_rdy) ex_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] op,
                         input logic [31:0] imm, input logic [4:0] rd);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    cur_op   = op;
    cur_imm  = imm;
    cur_rd   = rd;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] op,
                       input logic [31:0] imm, input logic [4:0] rd, output int unsigned n);
    present(ins, pc, op, imm, rd);
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted && n < 40);
    check("accepted", accepted, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    for (int unsigned i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    regs[0]  = '0;
    res      = 1'b0;
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    wb_rd    = '0;
    wb_data  = '0;
    cur_op   = K_ILL;

    // reset held two cycles, then released
    tick();
    tick();
    res = 1'b1;
    if_valid = 1'b0;
    tick();
    check("post_rst_pc", ex_pc, RST_PC);
    check("post_rst_valid", ex_valid, 1'b0);

    // addi x5,x0,42
    issue(32'h02A00293, 32'h100, K_OPIMM, 32'd42, 5'd5, cyc);
    check("addi_cyc", cyc, 1);
    check("addi_op", ex_op, K_OPIMM);
    check("addi_imm", ex_imm, 32'd42);
    check("addi_rd", ex_rd, 5'd5);
    check("addi_pc", ex_pc, 32'h100);

    // lw x10,0(x1) then dependent add x11,x10,x5
    issue(32'h0000A503, 32'h104, K_LOAD, 32'd0, 5'd10, cyc);
    check("lw_cyc", cyc, 1);
    issue(32'h005505B3, 32'h108, K_OPREG, 32'd0, 5'd11, cyc);
    check("luse_cyc", cyc, 3);

    // write-back collision on x5
    regs[5] = 32'd42;
    wb_rd   = 5'd5;
    wb_data = 32'd100;
    issue(32'h00028333, 32'h10C, K_OPREG, 32'd0, 5'd6, cyc);
`ifdef DECODE_BYPASS_EN
    check("wb_cyc", cyc, 1);
`else
    check("wb_cyc", cyc, 2);
`endif
    check("wb_rs1", ex_rs1_val, 32'd100);

    // execute back-pressure for 3 cycles, then flush
    issue(32'h02A00293, 32'h110, K_OPIMM, 32'd42, 5'd5, cyc);
    ex_ready = 1'b0;
    present(32'h402081B3, 32'h114, K_OPREG, 32'd0, 5'd3);
    for (int unsigned i = 0; i < 3; i++) tick();
    check("stall_pc", ex_pc, 32'h110);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", ex_valid, 1'b0);

    // flush beats a same-cycle accept
    ex_ready = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    check("flush_win", ex_valid, 1'b0);
    tick();

    // flush drops the pending load-use bubble
    issue(32'h0000A503, 32'h120, K_LOAD, 32'd0, 5'd10, cyc);
    present(32'h005505B3, 32'h124, K_OPREG, 32'd0, 5'd11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue(32'h005505B3, 32'h124, K_OPREG, 32'd0, 5'd11, cyc);
    check("flush_luse_cyc", cyc, 1);

    // all-zero word
    issue(32'h00000000, 32'h130, K_ILL, 32'd0, 5'd0, cyc);
    check("ill_op", ex_op, K_ILL);
    check("ill_rd", ex_rd, 5'd0);
    check("ill_imm", ex_imm, 32'd0);

    // table pass with steady ready, then with random ready
    for (int unsigned p = 0; p < 2; p++) begin
      rnd_rdy = (p == 1);
      for (int unsigned i = 0; i < 16; i++)
        issue(t_ins[i], 32'h200 + 32'(4 * i), t_op[i], t_imm[i], t_rd[i], cyc);
    end
    rnd_rdy  = 1'b0;
    ex_ready = 1'b1;
    if_valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) tick();
    check("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
